// File: rtl/rib_if.sv
// Bus bundle between the three core-side masters, the arbiter and the slave bus.
// The arbiter uses the slave modport; the environment (core, jtag, slaves) uses master.
interface rib_if #(
    parameter int SLV_NUM = 4
);
    logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
    logic        m0_req_i, m0_we_i, m0_ack_o, m0_err_o;
    logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
    logic        m1_req_i, m1_we_i, m1_ack_o, m1_err_o;
    logic [31:0] m2_addr_i, m2_data_i, m2_data_o;
    logic        m2_req_i, m2_we_i, m2_ack_o, m2_err_o;

    logic [31:0]               s_addr_o;
    logic [31:0]               s_data_o;
    logic                      s_we_o;
    logic [SLV_NUM-1:0]        s_sel_o;
    logic [SLV_NUM-1:0][31:0]  s_data_i;
    logic [SLV_NUM-1:0]        s_ack_i;

    logic                      hold_flag_o;
    logic [1:0]                grant_o;

    modport slave (
        input  m0_addr_i, m0_data_i, m0_req_i, m0_we_i,
        input  m1_addr_i, m1_data_i, m1_req_i, m1_we_i,
        input  m2_addr_i, m2_data_i, m2_req_i, m2_we_i,
        output m0_data_o, m0_ack_o, m0_err_o,
        output m1_data_o, m1_ack_o, m1_err_o,
        output m2_data_o, m2_ack_o, m2_err_o,
        output s_addr_o, s_data_o, s_we_o, s_sel_o,
        input  s_data_i, s_ack_i,
        output hold_flag_o, grant_o
    );

    modport master (
        output m0_addr_i, m0_data_i, m0_req_i, m0_we_i,
        output m1_addr_i, m1_data_i, m1_req_i, m1_we_i,
        output m2_addr_i, m2_data_i, m2_req_i, m2_we_i,
        input  m0_data_o, m0_ack_o, m0_err_o,
        input  m1_data_o, m1_ack_o, m1_err_o,
        input  m2_data_o, m2_ack_o, m2_err_o,
        input  s_addr_o, s_data_o, s_we_o, s_sel_o,
        output s_data_i, s_ack_i,
        input  hold_flag_o, grant_o
    );
endinterface

// File: rtl/rib_arbiter.sv
// Three-master fixed-priority arbiter onto a shared slave bus (IDLE/BUSY/RESP),
// with address-decoded slave select, bus timeout and a fetch hold flag for the core.
module rib_arbiter #(
    parameter int SLV_NUM = 4,
    parameter int TIMEOUT = 16
) (
    input logic clk,
    input logic rst,
    rib_if.slave bus
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [1:0] NO_GRANT = 2'd3;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    // master-side inputs gathered into arrays, index = master number
    logic [2:0]       req;
    logic [2:0][31:0] m_addr, m_wdata;
    logic [2:0]       m_we;

    assign req     = {bus.m2_req_i, bus.m1_req_i, bus.m0_req_i};
    assign m_addr  = {bus.m2_addr_i, bus.m1_addr_i, bus.m0_addr_i};
    assign m_wdata = {bus.m2_data_i, bus.m1_data_i, bus.m0_data_i};
    assign m_we    = {bus.m2_we_i, bus.m1_we_i, bus.m0_we_i};

    state_t              state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic [27:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [SLV_NUM-1:0]  sel_q, sel_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          ack_q, ack_d;
    logic [2:0]          err_q, err_d;
    logic [2:0][31:0]    data_q, data_d;

    logic [1:0]          win;
    logic [31:0]         win_addr, win_wdata;
    logic                win_we;
    logic [SLV_NUM-1:0]  dec;
    logic [31:0]         rsp_data;
    logic                hit;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        ack_d     = '0;
        err_d     = '0;
        data_d    = '0;
        win       = NO_GRANT;
        win_addr  = '0;
        win_wdata = '0;
        win_we    = 1'b0;
        dec       = '0;
        rsp_data  = '0;

        // sel_q is one-hot, so masking the acks drops strays from unselected slaves
        hit = |(bus.s_ack_i & sel_q);
        for (int k = 0; k < SLV_NUM; k++)
            if (sel_q[k]) rsp_data = bus.s_data_i[k];

        unique case (state_q)
            IDLE: begin
                // scan from lowest priority so the highest-priority requester lands last
                for (int i = 2; i >= 0; i--) begin
                    if (req[i]) begin
                        win       = 2'(i);
                        win_addr  = m_addr[i];
                        win_wdata = m_wdata[i];
                        win_we    = m_we[i];
                    end
                end
                for (int k = 0; k < SLV_NUM; k++)
                    dec[k] = (win_addr[31:28] == 4'(k));
                if (win != NO_GRANT) begin
                    grant_d = win;
                    addr_d  = win_addr[27:0];
                    wdata_d = win_wdata;
                    we_d    = win_we;
                    cnt_d   = '0;
                    if (|dec) begin
                        sel_d   = dec;
                        state_d = BUSY;
                    end else begin
                        state_d = RESP;
                        for (int i = 0; i < 3; i++)
                            if (win == 2'(i)) begin
                                ack_d[i] = 1'b1;
                                err_d[i] = 1'b1;
                            end
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (hit) begin
                    sel_d   = '0;
                    state_d = RESP;
                    for (int i = 0; i < 3; i++)
                        if (grant_q == 2'(i)) begin
                            ack_d[i]  = 1'b1;
                            data_d[i] = rsp_data;
                        end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    sel_d   = '0;
                    state_d = RESP;
                    for (int i = 0; i < 3; i++)
                        if (grant_q == 2'(i)) begin
                            ack_d[i] = 1'b1;
                            err_d[i] = 1'b1;
                        end
                end
            end
            RESP: begin
                state_d = IDLE;
                grant_d = NO_GRANT;
            end
            default: begin
                state_d = IDLE;
                grant_d = NO_GRANT;
                sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= NO_GRANT;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign bus.m0_ack_o  = ack_q[0];
    assign bus.m1_ack_o  = ack_q[1];
    assign bus.m2_ack_o  = ack_q[2];
    assign bus.m0_err_o  = err_q[0];
    assign bus.m1_err_o  = err_q[1];
    assign bus.m2_err_o  = err_q[2];
    assign bus.m0_data_o = data_q[0];
    assign bus.m1_data_o = data_q[1];
    assign bus.m2_data_o = data_q[2];

    assign bus.s_addr_o = {4'h0, addr_q};
    assign bus.s_data_o = wdata_q;
    assign bus.s_we_o   = we_q;
    assign bus.s_sel_o  = sel_q;
    assign bus.grant_o  = grant_q;

    // stall the core while fetch waits behind someone else
    assign bus.hold_flag_o = bus.m2_req_i &
                             (((state_q == IDLE) & (bus.m0_req_i | bus.m1_req_i)) |
                              ((state_q != IDLE) & (grant_q != 2'd2)));
endmodule

// File: tb/tb_rib_arbiter.sv
// Directed bench for rib_arbiter: reset abort, single read, priority, unmapped,
// timeout and wait-state/stray-ack cases with hand-computed expectations.
module tb_rib_arbiter;
    localparam int SLV_NUM = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    rib_if #(.SLV_NUM(SLV_NUM)) bus ();

    rib_arbiter #(.SLV_NUM(SLV_NUM), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] acks();
        return {29'd0, bus.m2_ack_o, bus.m1_ack_o, bus.m0_ack_o};
    endfunction

    function automatic logic [31:0] errs();
        return {29'd0, bus.m2_err_o, bus.m1_err_o, bus.m0_err_o};
    endfunction

    initial begin
        bus.m0_addr_i = '0; bus.m0_data_i = '0; bus.m0_req_i = 0; bus.m0_we_i = 0;
        bus.m1_addr_i = '0; bus.m1_data_i = '0; bus.m1_req_i = 0; bus.m1_we_i = 0;
        bus.m2_addr_i = '0; bus.m2_data_i = '0; bus.m2_req_i = 0; bus.m2_we_i = 0;
        bus.s_data_i  = '0; bus.s_ack_i = '0;

        repeat (3) step();
        chk("rst_grant", 32'(bus.grant_o), 32'd3);
        chk("rst_sel",   32'(bus.s_sel_o), 32'd0);
        chk("rst_ack",   acks(), 32'd0);
        chk("rst_addr",  bus.s_addr_o, 32'd0);
        rst = 1'b0;
        step();
        chk("idle_grant", 32'(bus.grant_o), 32'd3);

        // single read, zero-wait slave 1
        bus.m1_addr_i = 32'h1000_0040; bus.m1_we_i = 0; bus.m1_req_i = 1;
        bus.s_data_i[1] = 32'hCAFE_0001; bus.s_ack_i = 4'b0010;
        step();
        chk("rd_sel",   32'(bus.s_sel_o), 32'h2);
        chk("rd_addr",  bus.s_addr_o, 32'h0000_0040);
        chk("rd_grant", 32'(bus.grant_o), 32'd1);
        chk("rd_ack1",  acks(), 32'd0);
        step();
        chk("rd_ack2",  acks(), 32'b010);
        chk("rd_data",  bus.m1_data_o, 32'hCAFE_0001);
        chk("rd_err",   errs(), 32'd0);
        chk("rd_sel2",  32'(bus.s_sel_o), 32'd0);
        bus.m1_req_i = 0; bus.s_ack_i = '0;
        step();
        chk("rd_done", acks(), 32'd0);
        chk("rd_idle", 32'(bus.grant_o), 32'd3);

        // priority: all three to slave 0, zero-wait
        bus.m0_addr_i = 32'h0000_0010; bus.m1_addr_i = 32'h0000_0020; bus.m2_addr_i = 32'h0000_0030;
        bus.s_data_i[0] = 32'h1111_0000; bus.s_ack_i = 4'b0001;
        bus.m0_req_i = 1; bus.m1_req_i = 1; bus.m2_req_i = 1;
        #1;
        chk("pri_hold0", 32'(bus.hold_flag_o), 32'd1);
        for (int n = 1; n <= 8; n++) begin
            step();
            chk($sformatf("pri_ack%0d", n), acks(),
                (n == 2) ? 32'b001 : (n == 5) ? 32'b010 : (n == 8) ? 32'b100 : 32'd0);
            chk($sformatf("pri_hold%0d", n), 32'(bus.hold_flag_o), (n <= 5) ? 32'd1 : 32'd0);
            if (n == 4) chk("pri_addr_m1", bus.s_addr_o, 32'h0000_0020);
            if (n == 2) bus.m0_req_i = 0;
            if (n == 5) bus.m1_req_i = 0;
            if (n == 8) begin
                chk("pri_data_m2", bus.m2_data_o, 32'h1111_0000);
                bus.m2_req_i = 0;
            end
        end
        bus.s_ack_i = '0;
        step();

        // unmapped address
        bus.m2_addr_i = 32'h5000_0000; bus.m2_we_i = 0; bus.m2_req_i = 1;
        step();
        chk("um_ack",  acks(), 32'b100);
        chk("um_err",  errs(), 32'b100);
        chk("um_data", bus.m2_data_o, 32'd0);
        chk("um_sel",  32'(bus.s_sel_o), 32'd0);
        bus.m2_req_i = 0;
        step();
        chk("um_sel2", 32'(bus.s_sel_o), 32'd0);
        chk("um_done", acks(), 32'd0);

        // timeout on slave 2 write
        bus.m1_addr_i = 32'h2000_0000; bus.m1_data_i = 32'hDEAD_BEEF; bus.m1_we_i = 1; bus.m1_req_i = 1;
        for (int n = 1; n <= TIMEOUT + 1; n++) begin
            step();
            if (n <= TIMEOUT) begin
                chk($sformatf("to_sel%0d", n), 32'(bus.s_sel_o), 32'b0100);
                chk($sformatf("to_ack%0d", n), acks(), 32'd0);
            end else begin
                chk("to_ack", acks(), 32'b010);
                chk("to_err", errs(), 32'b010);
                chk("to_sel_off", 32'(bus.s_sel_o), 32'd0);
                bus.m1_req_i = 0; bus.m1_we_i = 0;
            end
            if (n == 1) begin
                chk("to_we",    32'(bus.s_we_o), 32'd1);
                chk("to_wdata", bus.s_data_o, 32'hDEAD_BEEF);
            end
        end
        step();

        // wait states on slave 3 with stray slave-0 acks
        bus.m0_addr_i = 32'h3000_0008; bus.m0_we_i = 0; bus.m0_req_i = 1;
        bus.s_data_i[3] = 32'h3333_AAAA; bus.s_data_i[0] = 32'h0BAD_0BAD;
        for (int n = 1; n <= 7; n++) begin
            step();
            bus.s_ack_i = {(n == 6), 2'b00, (n == 2 || n == 4)};
            chk($sformatf("ws_ack%0d", n), acks(), (n == 7) ? 32'b001 : 32'd0);
            if (n <= 6) chk($sformatf("ws_sel%0d", n), 32'(bus.s_sel_o), 32'b1000);
        end
        chk("ws_data", bus.m0_data_o, 32'h3333_AAAA);
        chk("ws_err",  errs(), 32'd0);
        bus.m0_req_i = 0; bus.s_ack_i = '0;
        step();

        // reset mid-BUSY aborts with no response
        bus.m0_addr_i = 32'h1000_0100; bus.m0_data_i = 32'h0000_A5A5; bus.m0_we_i = 1; bus.m0_req_i = 1;
        step();
        chk("ab_sel", 32'(bus.s_sel_o), 32'b0010);
        rst = 1'b1; bus.m0_req_i = 0; bus.m0_we_i = 0;
        for (int n = 1; n <= 3; n++) begin
            step();
            chk($sformatf("ab_sel%0d", n),   32'(bus.s_sel_o), 32'd0);
            chk($sformatf("ab_ack%0d", n),   acks() | errs(), 32'd0);
            chk($sformatf("ab_grant%0d", n), 32'(bus.grant_o), 32'd3);
            chk($sformatf("ab_bus%0d", n),   bus.s_addr_o | bus.s_data_o | 32'(bus.s_we_o), 32'd0);
        end
        rst = 1'b0;
        step();
        chk("ab_after_ack", acks(), 32'd0);
        chk("ab_after_grant", 32'(bus.grant_o), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
